// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the pipelined RV32I control unit.
package ctrl_pkg;

    localparam int OPC_W       = 5;
    localparam int ALUOP_WIDTH = 2;

    localparam logic [OPC_W-1:0] OPC_RTYPE  = 5'b01100;
    localparam logic [OPC_W-1:0] OPC_ITYPE  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_STORE  = 5'b01000;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 5'b11000;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_LUI    = 5'b01101;
    localparam logic [OPC_W-1:0] OPC_JAL    = 5'b11011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 5'b11001;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 5'b11100;
    localparam logic [OPC_W-1:0] OPC_FENCE  = 5'b00011;

    localparam logic [ALUOP_WIDTH-1:0] ALUOP_ADD    = 2'b00;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_IMM    = 2'b11;

    typedef struct packed {
        logic                   branch;
        logic                   mem_read;
        logic                   mem_to_reg;
        logic [ALUOP_WIDTH-1:0] alu_op;
        logic                   mem_write;
        logic                   alu_src;
        logic                   reg_write;
        logic                   jal;
        logic                   jalr;
        logic                   auipc;
        logic                   halt;
    } ctrl_bundle_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } pcu_state_e;

    // Writes to x0 are architecturally dropped, so strip RegWrite early.
    function automatic ctrl_bundle_t mask_x0_write(input ctrl_bundle_t b, input logic rd_is_zero);
        ctrl_bundle_t r;
        r           = b;
        r.reg_write = b.reg_write & ~rd_is_zero;
        return r;
    endfunction

endpackage

// File: rtl/pipe_control_unit_if.sv
// ID-side request/hazard signals and per-stage control outputs of the control unit.
interface pipe_control_unit_if #(
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 2
);
    logic              id_valid;
    logic [4:0]        id_opcode;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              ex_redirect;
    logic              stall_o;
    logic              flush_o;
    logic [ALUOP_W-1:0] ex_alu_op;
    logic              ex_alu_src;
    logic              ex_branch;
    logic              ex_jal;
    logic              ex_jalr;
    logic              ex_auipc;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_read;
    logic              mem_write;
    logic              mem_mem_to_reg;
    logic              mem_reg_write;
    logic [REG_AW-1:0] mem_rd;
    logic              wb_reg_write;
    logic              wb_mem_to_reg;
    logic [REG_AW-1:0] wb_rd;
    logic              halted;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_redirect,
        input  stall_o, flush_o, ex_alu_op, ex_alu_src, ex_branch, ex_jal, ex_jalr,
               ex_auipc, ex_rd, mem_read, mem_write, mem_mem_to_reg, mem_reg_write,
               mem_rd, wb_reg_write, wb_mem_to_reg, wb_rd, halted
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_redirect,
        output stall_o, flush_o, ex_alu_op, ex_alu_src, ex_branch, ex_jal, ex_jalr,
               ex_auipc, ex_rd, mem_read, mem_write, mem_mem_to_reg, mem_reg_write,
               mem_rd, wb_reg_write, wb_mem_to_reg, wb_rd, halted
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode[6:2] -> control bundle decoder.
// FENCE_NOP_EN: when defined, FENCE decodes as a NOP instead of halting.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic             valid,
    input  logic [OPC_W-1:0] opcode,
    output ctrl_bundle_t     bundle
);

    // Table lookup; unlisted opcodes and invalid slots yield an all-zero bubble.
    always_comb begin
        bundle = '0;
        if (valid) begin
            case (opcode)
                OPC_RTYPE: begin
                    bundle.alu_op    = ALUOP_RTYPE;
                    bundle.reg_write = 1'b1;
                end
                OPC_ITYPE, OPC_LUI: begin
                    bundle.alu_op    = ALUOP_IMM;
                    bundle.alu_src   = 1'b1;
                    bundle.reg_write = 1'b1;
                end
                OPC_LOAD: begin
                    bundle.mem_read   = 1'b1;
                    bundle.mem_to_reg = 1'b1;
                    bundle.alu_src    = 1'b1;
                    bundle.reg_write  = 1'b1;
                end
                OPC_STORE: begin
                    bundle.mem_write = 1'b1;
                    bundle.alu_src   = 1'b1;
                end
                OPC_BRANCH: begin
                    bundle.branch = 1'b1;
                    bundle.alu_op = ALUOP_BRANCH;
                end
                OPC_AUIPC: begin
                    bundle.auipc     = 1'b1;
                    bundle.reg_write = 1'b1;
                end
                OPC_JAL: begin
                    bundle.jal       = 1'b1;
                    bundle.reg_write = 1'b1;
                end
                OPC_JALR: begin
                    bundle.jalr      = 1'b1;
                    bundle.alu_src   = 1'b1;
                    bundle.reg_write = 1'b1;
                end
                OPC_SYSTEM: begin
                    bundle.halt = 1'b1;
                end
`ifdef FENCE_NOP_EN
                OPC_FENCE: begin
                    bundle = '0;
                end
`else
                OPC_FENCE: begin
                    bundle.halt = 1'b1;
                end
`endif
                default: begin
                    bundle = '0;
                end
            endcase
        end else begin
            bundle = '0;
        end
    end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control: ID decode, ID/EX-EX/MEM-MEM/WB control registers, load-use/redirect bubbles, halt drain FSM.
// FENCE_NOP_EN (see ctrl_decode) turns FENCE into a NOP.
module pipe_control_unit
    import ctrl_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 2
)(
    input  logic                clk,
    input  logic                rst_n,
    pipe_control_unit_if.slave  bus
);

    ctrl_bundle_t      id_bundle_s;
    ctrl_bundle_t      idex_next_s;
    logic [REG_AW-1:0] idex_rd_next_s;
    logic              load_use_s;
    logic              stall_s;
    logic              bubble_s;

    ctrl_bundle_t      idex_r;
    logic [REG_AW-1:0] idex_rd_r;
    logic              exmem_read_r;
    logic              exmem_write_r;
    logic              exmem_to_reg_r;
    logic              exmem_reg_write_r;
    logic              exmem_halt_r;
    logic [REG_AW-1:0] exmem_rd_r;
    logic              memwb_reg_write_r;
    logic              memwb_to_reg_r;
    logic [REG_AW-1:0] memwb_rd_r;
    pcu_state_e        state_r;
    logic              halted_r;

    ctrl_decode u_decode (
        .valid  (bus.id_valid),
        .opcode (bus.id_opcode),
        .bundle (id_bundle_s)
    );

    assign load_use_s = idex_r.mem_read && (idex_rd_r != '0) &&
                        ((idex_rd_r == bus.id_rs1) || (idex_rd_r == bus.id_rs2));

    // Stall/bubble selection; redirect wins over a load-use stall.
    always_comb begin
        stall_s  = (state_r != ST_RUN) || (load_use_s && !bus.ex_redirect);
        bubble_s = stall_s || bus.ex_redirect;
        if (bubble_s) begin
            idex_next_s    = '0;
            idex_rd_next_s = '0;
        end else begin
            idex_next_s    = mask_x0_write(id_bundle_s, bus.id_rd == '0);
            idex_rd_next_s = (id_bundle_s == '0) ? '0 : bus.id_rd;
        end
    end

    // Control pipeline registers; HALTED flushes every stage to bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_r            <= '0;
            idex_rd_r         <= '0;
            exmem_read_r      <= 1'b0;
            exmem_write_r     <= 1'b0;
            exmem_to_reg_r    <= 1'b0;
            exmem_reg_write_r <= 1'b0;
            exmem_halt_r      <= 1'b0;
            exmem_rd_r        <= '0;
            memwb_reg_write_r <= 1'b0;
            memwb_to_reg_r    <= 1'b0;
            memwb_rd_r        <= '0;
        end else if (state_r == ST_HALTED) begin
            idex_r            <= '0;
            idex_rd_r         <= '0;
            exmem_read_r      <= 1'b0;
            exmem_write_r     <= 1'b0;
            exmem_to_reg_r    <= 1'b0;
            exmem_reg_write_r <= 1'b0;
            exmem_halt_r      <= 1'b0;
            exmem_rd_r        <= '0;
            memwb_reg_write_r <= 1'b0;
            memwb_to_reg_r    <= 1'b0;
            memwb_rd_r        <= '0;
        end else begin
            idex_r            <= idex_next_s;
            idex_rd_r         <= idex_rd_next_s;
            exmem_read_r      <= idex_r.mem_read;
            exmem_write_r     <= idex_r.mem_write;
            exmem_to_reg_r    <= idex_r.mem_to_reg;
            exmem_reg_write_r <= idex_r.reg_write;
            exmem_halt_r      <= idex_r.halt;
            exmem_rd_r        <= idex_rd_r;
            memwb_reg_write_r <= exmem_reg_write_r;
            memwb_to_reg_r    <= exmem_to_reg_r;
            memwb_rd_r        <= exmem_rd_r;
        end
    end

    // Halt drain FSM; HALTED is reached as the halt bit moves into MEM/WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (!bubble_s && id_bundle_s.halt) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_RUN;
                    end
                    halted_r <= 1'b0;
                end
                ST_DRAIN: begin
                    if (exmem_halt_r) begin
                        state_r  <= ST_HALTED;
                        halted_r <= 1'b1;
                    end else begin
                        state_r  <= ST_DRAIN;
                        halted_r <= 1'b0;
                    end
                end
                ST_HALTED: begin
                    state_r  <= ST_HALTED;
                    halted_r <= 1'b1;
                end
                default: begin
                    state_r  <= ST_RUN;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stall_o        = stall_s;
    assign bus.flush_o        = bus.ex_redirect;
    assign bus.ex_alu_op      = ALUOP_W'(idex_r.alu_op);
    assign bus.ex_alu_src     = idex_r.alu_src;
    assign bus.ex_branch      = idex_r.branch;
    assign bus.ex_jal         = idex_r.jal;
    assign bus.ex_jalr        = idex_r.jalr;
    assign bus.ex_auipc       = idex_r.auipc;
    assign bus.ex_rd          = idex_rd_r;
    assign bus.mem_read       = exmem_read_r;
    assign bus.mem_write      = exmem_write_r;
    assign bus.mem_mem_to_reg = exmem_to_reg_r;
    assign bus.mem_reg_write  = exmem_reg_write_r;
    assign bus.mem_rd         = exmem_rd_r;
    assign bus.wb_reg_write   = memwb_reg_write_r;
    assign bus.wb_mem_to_reg  = memwb_to_reg_r;
    assign bus.wb_rd          = memwb_rd_r;
    assign bus.halted         = halted_r;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit with a per-stage expectation scoreboard.
module tb_pipe_control_unit;

    localparam logic [4:0] R   = 5'b01100;
    localparam logic [4:0] IA  = 5'b00100;
    localparam logic [4:0] LD  = 5'b00000;
    localparam logic [4:0] ST  = 5'b01000;
    localparam logic [4:0] BR  = 5'b11000;
    localparam logic [4:0] AUI = 5'b00101;
    localparam logic [4:0] LUI = 5'b01101;
    localparam logic [4:0] JAL = 5'b11011;
    localparam logic [4:0] JLR = 5'b11001;
    localparam logic [4:0] SYS = 5'b11100;
    localparam logic [4:0] FEN = 5'b00011;
    localparam logic [4:0] BAD = 5'b11111;
`ifdef FENCE_NOP_EN
    localparam bit FENCE_HALTS = 1'b0;
`else
    localparam bit FENCE_HALTS = 1'b1;
`endif

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src, branch, jal, jalr, auipc;
        logic       mem_read, mem_write, mem_to_reg, reg_write;
        logic [4:0] rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t ex_q[$];
    exp_t mem_q[$];
    exp_t wb_q[$];

    always #5 clk = ~clk;

    pipe_control_unit_if #(.REG_AW(5), .ALUOP_W(2)) bus ();

    pipe_control_unit #(.REG_AW(5), .ALUOP_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic exp_t exp_decode(input logic [4:0] opc, input logic [4:0] rd);
        exp_t e;
        logic carry;
        e     = '0;
        carry = 1'b1;
        case (opc)
            R:   begin e.alu_op = 2'b10; e.reg_write = 1'b1; end
            IA:  begin e.alu_op = 2'b11; e.alu_src = 1'b1; e.reg_write = 1'b1; end
            LD:  begin e.mem_read = 1'b1; e.mem_to_reg = 1'b1; e.alu_src = 1'b1; e.reg_write = 1'b1; end
            ST:  begin e.mem_write = 1'b1; e.alu_src = 1'b1; end
            BR:  begin e.branch = 1'b1; e.alu_op = 2'b01; end
            AUI: begin e.auipc = 1'b1; e.reg_write = 1'b1; end
            LUI: begin e.alu_op = 2'b11; e.alu_src = 1'b1; e.reg_write = 1'b1; end
            JAL: begin e.jal = 1'b1; e.reg_write = 1'b1; end
            JLR: begin e.jalr = 1'b1; e.alu_src = 1'b1; e.reg_write = 1'b1; end
            SYS: carry = 1'b1;
            FEN: carry = FENCE_HALTS;
            default: carry = 1'b0;
        endcase
        if (rd == 5'd0) e.reg_write = 1'b0;
        e.rd = carry ? rd : 5'd0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic prime();
        ex_q.delete(); mem_q.delete(); wb_q.delete();
        ex_q.push_back('0); mem_q.push_back('0); wb_q.push_back('0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(bus.stall_o), 32'd0);
        chk({tag, "_flush"}, 32'(bus.flush_o), 32'd0);
        chk({tag, "_halted"}, 32'(bus.halted), 32'd0);
        chk({tag, "_ex"}, 32'({bus.ex_alu_op, bus.ex_alu_src, bus.ex_branch, bus.ex_jal,
                               bus.ex_jalr, bus.ex_auipc, bus.ex_rd}), 32'd0);
        chk({tag, "_mem"}, 32'({bus.mem_read, bus.mem_write, bus.mem_mem_to_reg,
                                bus.mem_reg_write, bus.mem_rd}), 32'd0);
        chk({tag, "_wb"}, 32'({bus.wb_reg_write, bus.wb_mem_to_reg, bus.wb_rd}), 32'd0);
    endtask

    // Called on a negedge: asserts reset asynchronously, checks, releases on a later negedge.
    task automatic do_reset(input string tag);
        bus.id_valid = 1'b0; bus.id_opcode = 5'd0; bus.id_rs1 = 5'd0;
        bus.id_rs2 = 5'd0; bus.id_rd = 5'd0; bus.ex_redirect = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero(tag);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        prime();
    endtask

    task automatic step(input logic v, input logic [4:0] opc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic redir,
                        input logic e_stall, input logic e_bub, input logic e_halt);
        exp_t e_ex, e_mem, e_wb, e_new;
        bus.id_valid = v; bus.id_opcode = opc; bus.id_rs1 = rs1;
        bus.id_rs2 = rs2; bus.id_rd = rd; bus.ex_redirect = redir;
        #1;
        chk("stall", 32'(bus.stall_o), 32'(e_stall));
        chk("flush", 32'(bus.flush_o), 32'(redir));
        chk("halted", 32'(bus.halted), 32'(e_halt));
        e_ex = ex_q.pop_front(); e_mem = mem_q.pop_front(); e_wb = wb_q.pop_front();
        chk("ex", 32'({bus.ex_alu_op, bus.ex_alu_src, bus.ex_branch, bus.ex_jal, bus.ex_jalr,
                       bus.ex_auipc, bus.ex_rd}),
                  32'({e_ex.alu_op, e_ex.alu_src, e_ex.branch, e_ex.jal, e_ex.jalr,
                       e_ex.auipc, e_ex.rd}));
        chk("mem", 32'({bus.mem_read, bus.mem_write, bus.mem_mem_to_reg, bus.mem_reg_write,
                        bus.mem_rd}),
                   32'({e_mem.mem_read, e_mem.mem_write, e_mem.mem_to_reg, e_mem.reg_write,
                        e_mem.rd}));
        chk("wb", 32'({bus.wb_reg_write, bus.wb_mem_to_reg, bus.wb_rd}),
                  32'({e_wb.reg_write, e_wb.mem_to_reg, e_wb.rd}));
        e_new = (e_bub || !v) ? exp_t'('0) : exp_decode(opc, rd);
        wb_q.push_back(e_mem);
        mem_q.push_back(e_ex);
        ex_q.push_back(e_new);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1;
        bus.id_valid = 1'b0; bus.id_opcode = 5'd0; bus.id_rs1 = 5'd0;
        bus.id_rs2 = 5'd0; bus.id_rd = 5'd0; bus.ex_redirect = 1'b0;
        @(negedge clk);
        do_reset("reset");

        // decode table walk
        step(1'b1, R,   5'd2, 5'd3, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, IA,  5'd1, 5'd0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, LUI, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, AUI, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, JAL, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, JLR, 5'd1, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, BR,  5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // lw x5 ; add x6,x5,x1 -> one stall, add replayed
        step(1'b1, LD,  5'd2, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, R,   5'd5, 5'd1, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, R,   5'd5, 5'd1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        // lw x7 ; sw using x7 as rs2
        step(1'b1, LD,  5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, ST,  5'd3, 5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, ST,  5'd3, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // load to x0 never triggers a hazard
        step(1'b1, LD,  5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, R,   5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        // beq redirect squashes sw in ID
        step(1'b1, BR,  5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, ST,  5'd2, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        // add x0 and an unknown opcode, then an invalid slot
        step(1'b1, R,   5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, BAD, 5'd1, 5'd2, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, R,   5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        // redirect beats a load-use stall
        step(1'b1, LD,  5'd1, 5'd0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, R,   5'd8, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, R,   5'd8, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        // ecall squashed by redirect does not drain
        step(1'b1, SYS, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, R,   5'd2, 5'd3, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        // add then ecall: drain, halted three cycles after ID
        step(1'b1, R,   5'd1, 5'd2, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, SYS, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, R,   5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, R,   5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, R,   5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, R,   5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1);
        do_reset("halt_reset");

        // FENCE: halts unless built as a NOP
        step(1'b1, R,   5'd2, 5'd3, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, FEN, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, R,   5'd2, 5'd3, 5'd1, 1'b0, FENCE_HALTS, FENCE_HALTS, 1'b0);
        step(1'b1, R,   5'd2, 5'd3, 5'd1, 1'b0, FENCE_HALTS, FENCE_HALTS, 1'b0);
        step(1'b1, R,   5'd2, 5'd3, 5'd1, 1'b0, FENCE_HALTS, FENCE_HALTS, FENCE_HALTS);
        do_reset("fence_reset");

        // reset during DRAIN returns to RUN
        step(1'b1, SYS, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, R,   5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        do_reset("drain_reset");
        step(1'b1, R,   5'd1, 5'd2, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, IA,  5'd2, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, R,   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, R,   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_control_unit.md
Name: pipe_control_unit

Overview:
- Successor to the combinational opcode decoder in the pipelined RV32I core.
- Decodes opcode[6:2] in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and inserts bubbles; squashes on EX redirect.
- Runs a halt-drain FSM for ECALL/EBREAK/FENCE.

Parameters:
REG_AW, 5, register-address width for rs1/rs2/rd
ALUOP_W, 2, ALUOp field width (ALU decoder widens later)

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
id_valid  in  1  IF/ID holds a valid instruction
id_opcode  in  5  instruction[6:2]
id_rs1  in  REG_AW  source register 1
id_rs2  in  REG_AW  source register 2
id_rd  in  REG_AW  destination register
ex_redirect  in  1  branch taken, or jal/jalr resolved in EX
stall_o  out  1  hold PC and IF/ID
flush_o  out  1  clear IF/ID to bubble
ex_alu_op  out  ALUOP_W  ALUOp in EX
ex_alu_src, ex_branch, ex_jal, ex_jalr, ex_auipc  out  1 each  EX controls
ex_rd  out  REG_AW  EX destination register
mem_read, mem_write, mem_mem_to_reg, mem_reg_write  out  1 each  MEM controls
mem_rd  out  REG_AW  MEM destination register
wb_reg_write, wb_mem_to_reg  out  1 each  WB controls
wb_rd  out  REG_AW  WB destination register
halted  out  1  core halted

Behaviour:
- Clock and reset:
  - Single clock.
  - Reset is asynchronous and active-low.
  - At reset, every pipeline control register clears to 0 (bubble), the FSM enters RUN, and all outputs are 0.
- Decode table (bundle fields: Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite, jal, jalr, auipc, halt):
  - 01100 R: ALUOp=10, RegWrite=1.
  - 00100 I-ALU: ALUOp=11, ALUSrc=1, RegWrite=1.
  - 00000 load: MemRead=1, MemtoReg=1, ALUSrc=1, RegWrite=1.
  - 01000 store: MemWrite=1, ALUSrc=1.
  - 11000 branch: Branch=1, ALUOp=01.
  - 00101 auipc: auipc=1, RegWrite=1, Branch=0.
  - 01101 lui: ALUOp=11, ALUSrc=1, RegWrite=1.
  - 11011 jal: jal=1, RegWrite=1.
  - 11001 jalr: jalr=1, ALUSrc=1, RegWrite=1.
  - 11100 system: halt=1.
  - 00011 fence: halt=1.
  - Any other opcode, or id_valid=0: all-zero bundle.
  - Don't-care fields are driven 0 (never X).
- Pipelining and latency:
  - The bundle advances one stage per clock.
  - EX controls appear 1 cycle after ID, MEM after 2, WB after 3.
  - rd travels with the bundle.
  - rd=0 forces RegWrite=0 at the ID/EX capture.
- Load-use hazard, when ex MemRead=1, ex_rd!=0 and (ex_rd==id_rs1 or ex_rd==id_rs2):
  - stall_o=1 for exactly one cycle.
  - ID/EX loads a bubble; EX/MEM and MEM/WB advance.
  - Stores also compare rs2.
- Redirect: ex_redirect=1 drives flush_o=1 and loads a bubble into ID/EX that same edge. Redirect has priority over stall.
- Halt FSM, states RUN, DRAIN, HALTED:
  - RUN→DRAIN when a halt bundle is captured into ID/EX and ex_redirect=0 (with a redirect, the halt is squashed and the FSM stays in RUN).
  - DRAIN: stall_o=1, ID/EX loads bubbles, the halt bit travels to WB.
  - DRAIN→HALTED on the cycle the halt bit is in MEM/WB.
  - HALTED: halted=1, stall_o=1, all bundle registers hold bubbles. Only rst_n exits.
- Reset mid-drain: immediate return to RUN with bubbles.
- halted is registered, asserted 3 cycles after the halt instruction leaves ID.

Optional Feature:
- Macro FENCE_NOP_EN.
- Defined: opcode 00011 decodes to an all-zero bundle (NOP); no drain, no halt.
- Undefined: FENCE halts exactly as ECALL/EBREAK do.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams (OPC_RTYPE, OPC_ITYPE, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_AUIPC, OPC_LUI, OPC_JAL, OPC_JALR, OPC_SYSTEM, OPC_FENCE);
  - ALUOp encodings;
  - the ctrl_bundle_t packed struct;
  - the FSM state enum.
- One natural sub-module: ctrl_decode (pure combinational opcode→bundle). Hazard logic, pipeline registers and FSM stay in the top.

Test Plan:
- lw x5 then add x6,x5,x1 → stall_o=1 one cycle, ex_* all 0 that cycle, add reaches EX one cycle late with ex_alu_op=10.
- beq with ex_redirect=1 while sw in ID → flush_o=1; mem_write stays 0 for the squashed sw.
- ecall in ID, id_valid=1 → stall_o=1 from the next cycle, halted=1 exactly 3 cycles after ID; preceding add still sets wb_reg_write=1.
- Async rst_n low during DRAIN → all outputs 0 immediately, halted=0, FSM in RUN after release.
- FENCE opcode 00011 → halted rises with FENCE_NOP_EN undefined; no stall and halted stays 0 when it is defined.
- add x0,x1,x2 and opcode 11111 → wb_reg_write=0, no stall, bundle all 0 in every stage.
